bias_seq_ctrl_layer9: RTL and testbench

//  Sequencer for the layer-9 bias datapath. Walks the 3-bit bank select (u, banks 19..24)
//  and the 3-bit row select (z) of the combinational bias bank mux, and captures each selected
//  N_adder_tree*18-bit bias word into a holding register. Each captured word is offered to the

---
 rtl/bias_seq_ctrl_layer9_if.sv | 25 ++
 rtl/bias_seq_ctrl_layer9.sv | 108 ++++++++++
 tb/tb_bias_seq_ctrl_layer9.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bias_seq_ctrl_layer9_if.sv
// Bias sequencer bus: layer-controller start/status, bias mux select/data, adder-tree handshake.
// master = sequencer side, slave = environment (controller, bias mux, adder tree).
interface bias_seq_ctrl_layer9_if #(
  parameter int unsigned W = 288
);
  logic         start;
  logic [W-1:0] bias_in;
  logic [2:0]   z;
  logic [2:0]   u;
  logic [W-1:0] bias_q;
  logic         bias_valid;
  logic         bias_ready;
  logic         busy;
  logic         done;

  modport master (
    input  start, bias_in, bias_ready,
    output z, u, bias_q, bias_valid, busy, done
  );

  modport slave (
    output start, bias_in, bias_ready,
    input  z, u, bias_q, bias_valid, busy, done
  );
endinterface

// File: rtl/bias_seq_ctrl_layer9.sv
// Layer-9 bias sequencer: sweeps (u,z) over the bias mux, captures each word and offers it
// to the adder tree. Define BIAS_SEQ_PIPE_EN to add a second settle cycle before capture.
module bias_seq_ctrl_layer9 #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned N_ROWS       = 8,
  parameter int unsigned N_BANKS      = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  bias_seq_ctrl_layer9_if.master bus_io
);
  localparam int unsigned W     = N_adder_tree * 18;
  localparam logic [2:0]  LastZ = 3'(N_ROWS - 1);
  localparam logic [2:0]  LastU = 3'(N_BANKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSettle2,
    StCapture,
    StHold,
    StDone
  } state_e;

  state_e       state_q;
  logic [2:0]   z_q;
  logic [2:0]   u_q;
  logic [W-1:0] bias_q_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      z_q      <= 3'd0;
      u_q      <= 3'd0;
      bias_q_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q <= StSettle;
            z_q     <= 3'd0;
            u_q     <= 3'd0;
            busy_q  <= 1'b1;
          end
        end
        StSettle: begin
`ifdef BIAS_SEQ_PIPE_EN
          state_q <= StSettle2;
`else
          state_q <= StCapture;
`endif
        end
        StSettle2: begin
          state_q <= StCapture;
        end
        StCapture: begin
          bias_q_q <= bus_io.bias_in;
          valid_q  <= 1'b1;
          state_q  <= StHold;
        end
        StHold: begin
          if (valid_q && bus_io.bias_ready) begin
            valid_q <= 1'b0;
            if (z_q == LastZ && u_q == LastU) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // Row wrap moves to row 0 of the next bank.
              if (z_q == LastZ) begin
                z_q <= 3'd0;
                u_q <= u_q + 3'd1;
              end else begin
                z_q <= z_q + 3'd1;
              end
              state_q <= StSettle;
            end
          end
        end
        StDone: begin
          z_q     <= 3'd0;
          u_q     <= 3'd0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.z          = z_q;
  assign bus_io.u          = u_q;
  assign bus_io.bias_q     = bias_q_q;
  assign bus_io.bias_valid = valid_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;

endmodule

// File: tb/tb_bias_seq_ctrl_layer9.sv
// Scoreboard bench for bias_seq_ctrl_layer9: directed sweeps push expected (u,z,word) entries,
// a negedge monitor pops them on every handshake and checks word spacing and done timing.
module tb_bias_seq_ctrl_layer9;
  localparam int unsigned N = 16;
  localparam int unsigned W = N * 18;
`ifdef BIAS_SEQ_PIPE_EN
  localparam int ExpGap = 3;
`else
  localparam int ExpGap = 2;
`endif

  typedef struct {
    logic [2:0]   u;
    logic [2:0]   z;
    logic [W-1:0] w;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;
  int   cyc;
  int   last_hs_cyc;
  int   gap;
  bit   in_word;
  exp_t exp_q[$];

  bias_seq_ctrl_layer9_if #(.W(W)) bus ();

  bias_seq_ctrl_layer9 #(
    .N_adder_tree(N),
    .N_ROWS      (8),
    .N_BANKS     (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank mux model: every lane tagged with lane, u, z; banks u=6,7 read as zero.
  function automatic logic [W-1:0] model_word(input logic [2:0] uu, input logic [2:0] zz);
    logic [W-1:0] w;
    logic [7:0]   lo;
    w = '0;
    if (uu <= 3'd5) begin
      for (int l = 0; l < int'(N); l++) begin
        lo = 8'(l * 17) + {2'b00, uu, zz} + 8'h5A;
        w[l*18 +: 18] = {4'(l), uu, zz, lo};
      end
    end
    return w;
  endfunction

  assign bus.bias_in = model_word(bus.u, bus.z);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  // Monitor: handshakes pop the scoreboard, valid rises check settle gap, done checks timing.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      gap     = 0;
      in_word = 1'b0;
    end else begin
      if (bus.bias_valid) begin
        if (!in_word) begin
          chk_i("settle_gap", gap, ExpGap);
          in_word = 1'b1;
        end
        gap = 0;
        if (bus.bias_ready) begin
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk_i("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("word_u", W'(bus.u), W'(e.u));
            chk("word_z", W'(bus.z), W'(e.z));
            chk("word_data", bus.bias_q, e.w);
          end
        end
      end else begin
        in_word = 1'b0;
        if (bus.busy) gap++;
        else gap = 0;
      end
      if (bus.done) begin
        done_cnt++;
        chk_i("done_after_last_hs", cyc, last_hs_cyc + 1);
      end
    end
  end

  // One sweep; hu/hz/hn = backpressure point and length, su/sz = spurious start point,
  // ru/rz = mid-sweep reset point. Index 7 disables an option.
  task automatic run_sweep(input int hu, input int hz, input int hn, input int su, input int sz,
                           input int ru, input int rz, output bit was_reset);
    int lat;
    int held;
    bit sp;
    bit finished;
    int done_before;
    was_reset   = 1'b0;
    held        = 0;
    sp          = 1'b0;
    finished    = 1'b0;
    done_before = done_cnt;
    for (int uu = 0; uu < 6; uu++) begin
      for (int zz = 0; zz < 8; zz++) begin
        exp_q.push_back('{u: 3'(uu), z: 3'(zz), w: model_word(3'(uu), 3'(zz))});
      end
    end
    bus.bias_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.bias_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_i("start_latency", lat, ExpGap + 1);
    for (int c = 0; c < 2000 && !finished; c++) begin
      if (bus.done) begin
        bus.start = 1'b1;  // start during DONE must be ignored
        finished  = 1'b1;
      end else if (bus.bias_valid && int'(bus.u) == ru && int'(bus.z) == rz) begin
        bus.bias_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        was_reset = 1'b1;
        finished  = 1'b1;
      end else begin
        bus.bias_ready = 1'b1;
        if (bus.bias_valid && int'(bus.u) == hu && int'(bus.z) == hz && held < hn) begin
          bus.bias_ready = 1'b0;
          chk("hold_data", bus.bias_q, model_word(3'(hu), 3'(hz)));
          held++;
        end
        if (bus.bias_valid && int'(bus.u) == su && int'(bus.z) == sz && !sp) begin
          bus.start = 1'b1;
          sp = 1'b1;
        end
      end
      if (!was_reset) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    chk_i("sweep_terminated", int'(finished), 1);
    if (hn > 0) chk_i("hold_cycles", held, hn);
    if (!was_reset) begin
      repeat (3) @(posedge clk);
      #1;
      chk_i("sweep_words_left", exp_q.size(), 0);
      chk_i("sweep_done_count", done_cnt, done_before + 1);
      chk_i("idle_after_done", int'(bus.busy), 0);
    end
  endtask

  initial begin
    bit rs;
    int d0;
    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    cyc         = 0;
    last_hs_cyc = -10;
    rst_n       = 1'b0;
    bus.start      = 1'b0;
    bus.bias_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_z", W'(bus.z), '0);
    chk("rst_u", W'(bus.u), '0);
    chk("rst_bias_q", bus.bias_q, '0);
    chk("rst_valid", W'(bus.bias_valid), '0);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);

    run_sweep(7, 7, 0, 7, 7, 7, 7, rs);          // full sweep, ready held high
    run_sweep(1, 3, 10, 3, 2, 7, 7, rs);         // backpressure at (1,3), stray start at (3,2)

    d0 = done_cnt;
    run_sweep(7, 7, 0, 7, 7, 2, 5, rs);          // reset while holding (2,5)
    chk_i("reset_taken", int'(rs), 1);
    chk("midrst_z", W'(bus.z), '0);
    chk("midrst_u", W'(bus.u), '0);
    chk("midrst_valid", W'(bus.bias_valid), '0);
    chk("midrst_busy", W'(bus.busy), '0);
    repeat (10) @(posedge clk);
    #1;
    chk_i("midrst_no_done", done_cnt, d0);
    chk("midrst_still_idle", W'(bus.busy), '0);

    run_sweep(7, 7, 0, 7, 7, 7, 7, rs);          // recovers cleanly after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
